// File: rtl/fwd_pkg.sv
// Shared types for the forwarding scoreboard: register numbers and producer tags.
package fwd_pkg;

  typedef logic [4:0] reg_addr_t;

  typedef struct packed {
    logic      v;
    reg_addr_t waddr;
  } fwd_tag_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_port_sel.sv
// One read-port priority selector: matches the operand against every tracked
// producer, picks the youngest (lowest stage, then highest lane) and flags a stall.
module fwd_port_sel
  import fwd_pkg::*;
#(
  parameter int unsigned LANES  = 2,
  parameter int unsigned STAGES = 2,
  parameter int unsigned DW     = 32
) (
  input  logic [STAGES*LANES-1:0]    tag_v,
  input  logic [STAGES*LANES*5-1:0]  tag_waddr,
  input  logic [STAGES*LANES*DW-1:0] stg_wdata,
  input  logic [STAGES*LANES-1:0]    stg_wok,
  input  reg_addr_t                  rd_addr,
  input  logic [DW-1:0]              rd_rfdata,
  output logic [DW-1:0]              value,
  output logic                       hit,
  output logic                       stall
);

  logic          found;
  logic          win_ok;
  logic [DW-1:0] win_data;
  int unsigned   idx;

  // Scan oldest to youngest so the last match seen is the winner.
  always_comb begin
    found    = 1'b0;
    win_ok   = 1'b0;
    win_data = '0;
    idx      = 0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        idx = (STAGES - 1 - i) * LANES + l;
        if (tag_v[idx] && (tag_waddr[idx*5 +: 5] == rd_addr) && (rd_addr != REG_ZERO)) begin
          found    = 1'b1;
          win_ok   = stg_wok[idx];
          win_data = stg_wdata[idx*DW +: DW];
        end
      end
    end
  end

  always_comb begin
    hit   = found && win_ok;
    stall = found && !win_ok;
    value = hit ? win_data : rd_rfdata;
  end

endmodule

// File: rtl/forward_scoreboard.sv
// Operand forwarding scoreboard with its own producer-tag pipeline.
// Optional FWD_PERF_CNT_EN adds saturating stall/forward cycle counters.
module forward_scoreboard
  import fwd_pkg::*;
#(
  parameter int unsigned LANES    = 2,
  parameter int unsigned STAGES   = 2,
  parameter int unsigned RD_PORTS = 4,
  parameter int unsigned DW       = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       adv,
  input  logic [STAGES-1:0]          flush,
  input  logic [LANES-1:0]           iss_wen,
  input  logic [LANES*5-1:0]         iss_waddr,
  input  logic [STAGES*LANES*DW-1:0] stg_wdata,
  input  logic [STAGES*LANES-1:0]    stg_wok,
  input  logic [RD_PORTS*5-1:0]      rd_addr,
  input  logic [RD_PORTS*DW-1:0]     rd_rfdata,
  output logic [RD_PORTS*DW-1:0]     rd_value,
  output logic [RD_PORTS-1:0]        rd_hit,
  output logic                       fwd_stall,
  output logic                       intra_dep,
`ifdef FWD_PERF_CNT_EN
  output logic [31:0]                perf_stall_cnt,
  output logic [31:0]                perf_fwd_cnt,
`endif
  output logic [STAGES*LANES-1:0]    stg_wen_q
);

  fwd_tag_t                  tag_q [STAGES][LANES];
  logic [STAGES*LANES-1:0]   tag_v;
  logic [STAGES*LANES*5-1:0] tag_waddr;
  logic [RD_PORTS-1:0]       port_stall;

  // Flush masks the valid bit after the shift, so it beats a same-edge shift-in.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      if (s == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (!resetn) begin
            tag_q[s][l] <= '0;
          end else if (adv) begin
            tag_q[s][l].v     <= iss_wen[l] && (iss_waddr[l*5 +: 5] != REG_ZERO) && !flush[s];
            tag_q[s][l].waddr <= iss_waddr[l*5 +: 5];
          end else begin
            tag_q[s][l].v <= tag_q[s][l].v && !flush[s];
          end
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (!resetn) begin
            tag_q[s][l] <= '0;
          end else if (adv) begin
            tag_q[s][l].v     <= tag_q[s-1][l].v && !flush[s];
            tag_q[s][l].waddr <= tag_q[s-1][l].waddr;
          end else begin
            tag_q[s][l].v <= tag_q[s][l].v && !flush[s];
          end
        end
      end
    end
  end

  always_comb begin
    tag_v     = '0;
    tag_waddr = '0;
    for (int unsigned s = 0; s < STAGES; s++) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        tag_v[s*LANES+l]             = tag_q[s][l].v;
        tag_waddr[(s*LANES+l)*5 +: 5] = tag_q[s][l].waddr;
      end
    end
  end

  assign stg_wen_q = tag_v;

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
    fwd_port_sel #(
      .LANES  (LANES),
      .STAGES (STAGES),
      .DW     (DW)
    ) u_sel (
      .tag_v     (tag_v),
      .tag_waddr (tag_waddr),
      .stg_wdata (stg_wdata),
      .stg_wok   (stg_wok),
      .rd_addr   (rd_addr[p*5 +: 5]),
      .rd_rfdata (rd_rfdata[p*DW +: DW]),
      .value     (rd_value[p*DW +: DW]),
      .hit       (rd_hit[p]),
      .stall     (port_stall[p])
    );
  end

  assign fwd_stall = |port_stall;

  // Port p belongs to lane p/2; it depends on any older lane in the same bundle.
  always_comb begin
    intra_dep = 1'b0;
    for (int unsigned p = 0; p < RD_PORTS; p++) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        if ((l < p / 2) && iss_wen[l] && (iss_waddr[l*5 +: 5] != REG_ZERO)
            && (iss_waddr[l*5 +: 5] == rd_addr[p*5 +: 5])) begin
          intra_dep = 1'b1;
        end
      end
    end
  end

`ifdef FWD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_stall_cnt <= '0;
      perf_fwd_cnt   <= '0;
    end else begin
      if (fwd_stall && (perf_stall_cnt != '1)) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if ((|rd_hit) && (perf_fwd_cnt != '1))   perf_fwd_cnt   <= perf_fwd_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_forward_scoreboard.sv
// Scoreboard bench for forward_scoreboard: directed scenarios plus random traffic
// checked against a program-order producer model.
module tb_forward_scoreboard;

  localparam int LANES    = 2;
  localparam int STAGES   = 2;
  localparam int RD_PORTS = 4;
  localparam int DW       = 32;

  logic                       clk;
  logic                       resetn;
  logic                       adv;
  logic [STAGES-1:0]          flush;
  logic [LANES-1:0]           iss_wen;
  logic [LANES*5-1:0]         iss_waddr;
  logic [STAGES*LANES*DW-1:0] stg_wdata;
  logic [STAGES*LANES-1:0]    stg_wok;
  logic [RD_PORTS*5-1:0]      rd_addr;
  logic [RD_PORTS*DW-1:0]     rd_rfdata;
  logic [RD_PORTS*DW-1:0]     rd_value;
  logic [RD_PORTS-1:0]        rd_hit;
  logic                       fwd_stall;
  logic                       intra_dep;
  logic [STAGES*LANES-1:0]    stg_wen_q;

  forward_scoreboard #(
    .LANES    (LANES),
    .STAGES   (STAGES),
    .RD_PORTS (RD_PORTS),
    .DW       (DW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .adv       (adv),
    .flush     (flush),
    .iss_wen   (iss_wen),
    .iss_waddr (iss_waddr),
    .stg_wdata (stg_wdata),
    .stg_wok   (stg_wok),
    .rd_addr   (rd_addr),
    .rd_rfdata (rd_rfdata),
    .rd_value  (rd_value),
    .rd_hit    (rd_hit),
    .fwd_stall (fwd_stall),
    .intra_dep (intra_dep),
    .stg_wen_q (stg_wen_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [RD_PORTS*DW-1:0]  value;
    logic [RD_PORTS-1:0]     hit;
    logic                    stall;
    logic                    intra;
    logic [STAGES*LANES-1:0] wen_q;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   known = 0;

  // Producers in flight: index 0 = issued most recently (E), per lane.
  bit        prod_v [STAGES][LANES];
  logic [4:0] prod_a [STAGES][LANES];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Youngest writer in program order: later bundle first, then later lane.
  function automatic exp_t compute();
    exp_t e;
    e.value = '0; e.hit = '0; e.stall = 1'b0; e.intra = 1'b0; e.wen_q = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      logic [4:0]    a;
      bit            found, ok;
      logic [DW-1:0] d;
      a = rd_addr[p*5 +: 5]; found = 0; ok = 0; d = '0;
      for (int age = STAGES - 1; age >= 0; age--)
        for (int l = 0; l < LANES; l++)
          if (prod_v[age][l] && prod_a[age][l] == a && a != 0) begin
            found = 1; ok = stg_wok[age*LANES+l]; d = stg_wdata[(age*LANES+l)*DW +: DW];
          end
      e.hit[p] = found && ok;
      e.value[p*DW +: DW] = (found && ok) ? d : rd_rfdata[p*DW +: DW];
      if (found && !ok) e.stall = 1'b1;
      for (int l = 0; l < p / 2 && l < LANES; l++)
        if (iss_wen[l] && iss_waddr[l*5 +: 5] != 0 && iss_waddr[l*5 +: 5] == a) e.intra = 1'b1;
    end
    for (int s = 0; s < STAGES; s++)
      for (int l = 0; l < LANES; l++) e.wen_q[s*LANES+l] = prod_v[s][l];
    return e;
  endfunction

  task automatic model_edge();
    if (!resetn) begin
      foreach (prod_v[s, l]) begin prod_v[s][l] = 0; prod_a[s][l] = '0; end
    end else begin
      if (adv) begin
        for (int s = STAGES - 1; s > 0; s--)
          for (int l = 0; l < LANES; l++) begin
            prod_v[s][l] = prod_v[s-1][l];
            prod_a[s][l] = prod_a[s-1][l];
          end
        for (int l = 0; l < LANES; l++) begin
          prod_a[0][l] = iss_waddr[l*5 +: 5];
          prod_v[0][l] = iss_wen[l] && iss_waddr[l*5 +: 5] != 0;
        end
      end
      for (int s = 0; s < STAGES; s++)
        if (flush[s]) for (int l = 0; l < LANES; l++) prod_v[s][l] = 0;
    end
  endtask

  task automatic apply();
    if (known) exp_q.push_back(compute());
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_edge();
    if (!resetn) known = 1;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    resetn = 1'b1; adv = 1'b0; flush = '0; iss_wen = '0; iss_waddr = '0;
    stg_wdata = '0; stg_wok = '0; rd_addr = '0; rd_rfdata = '0;
  endtask

  // Monitor: outputs are combinational and valid a little after each negedge.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        for (int p = 0; p < RD_PORTS; p++)
          chk($sformatf("rd_value[%0d]", p), 64'(rd_value[p*DW +: DW]), 64'(e.value[p*DW +: DW]));
        chk("rd_hit", 64'(rd_hit), 64'(e.hit));
        chk("fwd_stall", 64'(fwd_stall), 64'(e.stall));
        chk("intra_dep", 64'(intra_dep), 64'(e.intra));
        chk("stg_wen_q", 64'(stg_wen_q), 64'(e.wen_q));
      end
    end
  end

  initial begin
    idle_inputs();
    resetn = 1'b0;
    @(negedge clk);
    apply(); finish_cycle();
    apply(); finish_cycle();
    resetn = 1'b1;

    // Reset state: regfile passthrough.
    rd_addr[4:0] = 5'd5; rd_rfdata[31:0] = 32'h11;
    apply(); #2;
    chk("reset_value", 64'(rd_value[31:0]), 64'h11);
    chk("reset_hit", 64'(rd_hit), 64'h0);
    chk("reset_stall", 64'(fwd_stall), 64'h0);
    chk("reset_wen_q", 64'(stg_wen_q), 64'h0);
    finish_cycle();

    // Lane0 issues r5, then forward from E.
    iss_wen = 2'b01; iss_waddr[4:0] = 5'd5; adv = 1'b1;
    apply(); finish_cycle();
    iss_wen = '0; adv = 1'b0; stg_wdata[31:0] = 32'hAA; stg_wok = '1;
    apply(); #2;
    chk("e_fwd_value", 64'(rd_value[31:0]), 64'hAA);
    chk("e_fwd_hit", 64'(rd_hit[0]), 64'h1);
    finish_cycle();

    // Both lanes write r7: lane1 wins.
    iss_wen = 2'b11; iss_waddr = {5'd7, 5'd7}; adv = 1'b1;
    apply(); finish_cycle();
    iss_wen = '0; adv = 1'b0; rd_addr[4:0] = 5'd7;
    stg_wdata[31:0] = 32'h1; stg_wdata[63:32] = 32'h2;
    apply(); #2;
    chk("lane_prio", 64'(rd_value[31:0]), 64'h2);
    finish_cycle();

    // r9 ready in M, not ready in E: stall, then release.
    iss_wen = 2'b01; iss_waddr = {5'd0, 5'd9}; adv = 1'b1;
    apply(); finish_cycle();
    apply(); finish_cycle();
    iss_wen = '0; adv = 1'b0; rd_addr[4:0] = 5'd9; rd_rfdata[31:0] = 32'h55;
    stg_wdata = '0; stg_wdata[95:64] = 32'h33; stg_wok = 4'b0100;
    apply(); #2;
    chk("stall_set", 64'(fwd_stall), 64'h1);
    chk("stall_hit", 64'(rd_hit[0]), 64'h0);
    finish_cycle();
    stg_wdata[31:0] = 32'h44; stg_wok = 4'b0101;
    apply(); #2;
    chk("stall_release_value", 64'(rd_value[31:0]), 64'h44);
    chk("stall_release", 64'(fwd_stall), 64'h0);
    finish_cycle();

    // Issue r3 with a same-edge E flush.
    iss_wen = 2'b01; iss_waddr = {5'd0, 5'd3}; adv = 1'b1; flush = 2'b01;
    apply(); finish_cycle();
    iss_wen = '0; adv = 1'b0; flush = '0; rd_addr[4:0] = 5'd3; rd_rfdata[31:0] = 32'h77; stg_wok = '1;
    apply(); #2;
    chk("flush_value", 64'(rd_value[31:0]), 64'h77);
    chk("flush_hit", 64'(rd_hit[0]), 64'h0);
    finish_cycle();

    // Intra-bundle dependency, then the same with r0.
    iss_wen = 2'b01; iss_waddr = {5'd0, 5'd4}; rd_addr = '0; rd_addr[14:10] = 5'd4;
    apply(); #2;
    chk("intra_dep_r4", 64'(intra_dep), 64'h1);
    finish_cycle();
    iss_waddr = '0; rd_addr[14:10] = 5'd0;
    apply(); #2;
    chk("intra_dep_r0", 64'(intra_dep), 64'h0);
    chk("r0_no_hit", 64'(rd_hit[2]), 64'h0);
    finish_cycle();

    // Random traffic over a small register range to provoke collisions.
    for (int c = 0; c < 600; c++) begin
      resetn    = ($urandom_range(0, 39) != 0);
      adv       = $urandom_range(0, 2) != 0;
      flush     = ($urandom_range(0, 5) == 0) ? STAGES'($urandom) : '0;
      iss_wen   = LANES'($urandom);
      for (int l = 0; l < LANES; l++) iss_waddr[l*5 +: 5] = 5'($urandom_range(0, 7));
      for (int i = 0; i < STAGES * LANES; i++) stg_wdata[i*DW +: DW] = $urandom;
      stg_wok   = STAGES*LANES'($urandom);
      for (int p = 0; p < RD_PORTS; p++) begin
        rd_addr[p*5 +: 5]    = 5'($urandom_range(0, 7));
        rd_rfdata[p*DW +: DW] = $urandom;
      end
      apply();
      finish_cycle();
    end

    idle_inputs();
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
